// File: rtl/truth_table_preimage_scanner.sv
// Purpose: inverts a packed N_IN-in/N_OUT-out truth table, streaming every input vector that maps to the queried code.
// Latency: first beat 1 cycle after query accept; k matches drain in k cycles; a code with no preimage returns one "none" beat.
// Backpressure: beats hold stable while m_ready is low; q_ready is high only in IDLE, so queries stall for the whole burst.
module truth_table_preimage_scanner #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4,
    parameter logic [(N_OUT<<N_IN)-1:0] TT = 32'h6C9C6090
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [N_OUT-1:0] q_code,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N_IN-1:0]  m_input,
    output logic             m_last,
    output logic             m_none,
    output logic [N_IN:0]    m_count
);

    localparam int NE = 1 << N_IN;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_NONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [NE-1:0] match_q, match_d;
    logic [N_IN:0] count_q, count_d;

    logic [NE-1:0] hits;
    logic [N_IN:0] hit_count;
    logic [N_IN-1:0] first_idx;
    logic          match_rest;   // any match bit remains besides the lowest one

    // Compare the incoming code against every table entry and count the hits.
    always_comb begin
        hits      = '0;
        hit_count = '0;
        for (int i = 0; i < NE; i++) begin
            hits[i]   = (TT[i*N_OUT +: N_OUT] == q_code);
            hit_count = hit_count + (N_IN+1)'(hits[i]);
        end
    end

    // Priority-encode the lowest pending match so beats leave in ascending index order.
    always_comb begin
        first_idx = '0;
        for (int i = NE - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                first_idx = N_IN'(i);
            end
        end
        match_rest = |(match_q & (match_q - NE'(1)));
    end

    // Next-state: latch the match vector at accept, retire one bit per handshake.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (q_valid) begin
                    match_d = hits;
                    count_d = hit_count;
                    state_d = (|hits) ? ST_EMIT : ST_NONE;
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    // x & (x-1) drops exactly the lowest set bit
                    match_d = match_q & (match_q - NE'(1));
                    if (!match_rest) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_NONE: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any burst in progress immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            match_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    // Outputs decode from registered state only; no path from q_* to m_*.
    always_comb begin
        q_ready = (state_q == ST_IDLE);
        m_valid = (state_q == ST_EMIT) || (state_q == ST_NONE);
        m_none  = (state_q == ST_NONE);
        m_input = (state_q == ST_EMIT) ? first_idx : '0;
        m_last  = ((state_q == ST_EMIT) && !match_rest) || (state_q == ST_NONE);
        // A no-match query latched a zero popcount, so NONE reports 0 naturally.
        m_count = count_q;
    end

endmodule

// File: doc/truth_table_preimage_scanner.md
Name: truth_table_preimage_scanner

Overview:
- Inverse (decode) side of a 3-in/4-out combinational truth-table block: given an observed output code, streams back every input combination that produces it.
- The forward function is many-to-one, so the response can be a multi-beat burst. A query with no matching input returns a single "none" beat.
- Used by netlist-verification benches and the synthesis flow to check that each output code is reachable and to list its preimages.

Parameters:
- N_IN, 3, number of function inputs; the table has 2^N_IN entries.
- N_OUT, 4, output code width.
- TT, 32'h6C9C6090, packed truth table. Entry i sits at TT[i*N_OUT +: N_OUT], ordered {out1,out2,out3,out4}, where i is the input vector {in1,in2,in3}. Width is N_OUT<<N_IN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- q_valid  input  1  query present.
- q_ready  output  1  block can accept a query; high only in IDLE.
- q_code  input  N_OUT  output code to invert.
- m_valid  output  1  response beat valid.
- m_ready  input  1  consumer accepts beat.
- m_input  output  N_IN  matching input vector, {in1,in2,in3}.
- m_last  output  1  final beat of the response.
- m_none  output  1  beat signals that no input maps to q_code.
- m_count  output  N_IN+1  total preimage count for the current query, 0..2^N_IN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, q_ready=1, m_valid=0, m_input=0, m_last=0, m_none=0, m_count=0.
  - Match vector and code register cleared.
- States: IDLE, EMIT, NONE.
- IDLE:
  - q_ready=1.
  - Query accepted in cycle T when q_valid&q_ready.
  - At that edge: register match[i] = (TT entry i == q_code) for all i, and m_count = popcount(match).
  - Next state is EMIT if match!=0, else NONE.
- EMIT:
  - From T+1: m_valid=1, m_input = index of lowest set bit of match, m_none=0.
  - m_last=1 iff no other match bit is set.
  - On m_valid&m_ready: clear that bit. If it was last, go to IDLE; otherwise present the next lowest set bit in the next cycle.
  - One beat per cycle under continuous m_ready.
- NONE:
  - m_valid=1, m_input=0, m_none=1, m_last=1, m_count=0.
  - On m_ready: go to IDLE.
- Stability:
  - While m_valid=1 and m_ready=0, m_input, m_last, m_none and m_count hold stable.
  - m_valid is never dropped without a handshake.
- Return to IDLE:
  - After the last handshake: m_valid=0, m_last=0, m_none=0 in the IDLE cycle.
  - q_ready=1 in that same cycle, so the next query can be accepted there.
  - m_count holds its last value until the next accept.
- q_code changes while q_ready=0 are ignored; the query is latched only at accept.
- Beat ordering: strictly ascending input index.
- Latency: first beat valid 1 cycle after accept. Burst of k matches completes in k cycles with m_ready held high. Query-to-query minimum spacing is k+1 cycles.
- Boundaries:
  - All 2^N_IN entries match: 2^N_IN beats; m_count = 2^N_IN, which needs the N_IN+1 bit width.
  - m_ready high while m_valid=0: no effect.
  - q_valid held high across a burst: not accepted until IDLE.
- Reset mid-burst: aborts immediately (asynchronous). Outputs return to reset values; no partial-burst resume.
- No combinational path from q_valid/q_code to any m_* output. q_ready depends on state only.

Test Plan:
- Default TT, query 4'b1001, m_ready=1:
  - Accept at T.
  - T+1: m_input=3'b001, m_last=0, m_count=2.
  - T+2: m_input=3'b101, m_last=1.
  - T+3: q_ready=1.
- Query 4'b1111: single beat, m_none=1, m_last=1, m_input=0, m_count=0; then IDLE.
- Query 4'b0000 with m_ready low for 3 cycles:
  - m_input=3'b000 held stable 3 cycles, then handshake.
  - Next beat 3'b010, m_last=1.
- TT=32'h0 and query 4'b0000: 8 beats 000..111 in order, m_last only on 111, m_count=4'd8.
- Back-to-back queries 0110 then 1100:
  - 0110 returns {011,111}; 1100 returns {100,110}.
  - Second query accepted in the cycle after the first burst's last handshake.
  - q_ready=0 throughout each burst, even with q_valid held high.
- Reset asserted mid-burst (after first beat of 1001, m_ready=0):
  - Outputs go to reset values asynchronously; q_ready=1.
  - A fresh query 1001 after release restarts from 3'b001.
